// File: rtl/fft_input_unpacker.sv
// Buffers one frame of wide host lines, then streams it to the FFT core one sample per handshake.
// Define FFT_IN_BITREV_EN to emit samples in bit-reversed order (decimation-in-time input).
module fft_input_unpacker #(
  parameter int SIZE       = 16,
  parameter int SAMPLES    = 2048,
  parameter int INPUT_SIZE = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [INPUT_SIZE-1:0]      line_in,
  input  logic                       line_valid,
  output logic                       line_ready,
  output logic [SIZE-1:0]            sample_out,
  output logic [$clog2(SAMPLES)-1:0] sample_index,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int LINES_PER_FRAME  = SAMPLES * SIZE / INPUT_SIZE;
  localparam int SAMPLES_PER_LINE = INPUT_SIZE / SIZE;
  localparam int IDX_W            = $clog2(SAMPLES);
  localparam int LINE_W           = $clog2(LINES_PER_FRAME);
  localparam int SLOT_W           = $clog2(SAMPLES_PER_LINE);

  localparam logic [LINE_W-1:0] LAST_LINE   = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [IDX_W-1:0]  LAST_SAMPLE = IDX_W'(SAMPLES - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // One storage word per host line; slot k of a word is the k-th sample of that line.
  logic [SAMPLES_PER_LINE-1:0][SIZE-1:0] r_mem [LINES_PER_FRAME];

  logic [LINE_W-1:0] r_lineCnt;
  logic [IDX_W-1:0]  r_readCnt;
  logic [SIZE-1:0]   r_sampleOut;
  logic [IDX_W-1:0]  r_sampleIndex;
  logic              r_sampleValid;
  logic              r_frameDone;

  logic                                  w_lineXfer;
  logic                                  w_sampleXfer;
  logic                                  w_lastLine;
  logic                                  w_lastSample;
  logic [IDX_W-1:0]                      w_readCntNext;
  logic [IDX_W-1:0]                      w_readAddr;
  logic [SAMPLES_PER_LINE-1:0][SIZE-1:0] w_readLine;
  logic [SIZE-1:0]                       w_readSample;

`ifdef FFT_IN_BITREV_EN
  function automatic logic [IDX_W-1:0] bitRev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < IDX_W; i++) r[i] = v[IDX_W-1-i];
    return r;
  endfunction
`endif

  assign w_lineXfer   = line_valid && (r_state == FILL);
  assign w_sampleXfer = r_sampleValid && sample_ready;
  assign w_lastLine   = (r_lineCnt == LAST_LINE);
  assign w_lastSample = (r_readCnt == LAST_SAMPLE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL:    if (w_lineXfer && w_lastLine) w_nextState = DRAIN;
      DRAIN:   if (w_sampleXfer && w_lastSample) w_nextState = FILL;
      default: w_nextState = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lineCnt <= '0;
    end else if (w_lineXfer) begin
      r_lineCnt <= w_lastLine ? '0 : r_lineCnt + 1'b1;
    end
  end

  // Storage is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_lineXfer) r_mem[r_lineCnt] <= line_in;
  end

  // Look up the sample that will be on the outputs after this edge, so a held-high
  // sample_ready sees one sample per cycle.
  always_comb begin
    w_readCntNext = r_readCnt;
    if (w_sampleXfer) w_readCntNext = w_lastSample ? '0 : r_readCnt + 1'b1;
  end

`ifdef FFT_IN_BITREV_EN
  assign w_readAddr = bitRev(w_readCntNext);
`else
  assign w_readAddr = w_readCntNext;
`endif

  assign w_readLine   = r_mem[w_readAddr[IDX_W-1 -: LINE_W]];
  assign w_readSample = w_readLine[w_readAddr[SLOT_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_readCnt     <= '0;
      r_sampleOut   <= '0;
      r_sampleIndex <= '0;
      r_sampleValid <= 1'b0;
      r_frameDone   <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (r_state == DRAIN) begin
        r_readCnt <= w_readCntNext;
        if (w_sampleXfer && w_lastSample) begin
          r_sampleValid <= 1'b0;
          r_frameDone   <= 1'b1;
        end else if (!r_sampleValid || w_sampleXfer) begin
          r_sampleValid <= 1'b1;
          r_sampleOut   <= w_readSample;
          r_sampleIndex <= w_readAddr;
        end
      end
    end
  end

  assign line_ready   = (r_state == FILL);
  assign busy         = (r_state == DRAIN);
  assign sample_out   = r_sampleOut;
  assign sample_index = r_sampleIndex;
  assign sample_valid = r_sampleValid;
  assign frame_done   = r_frameDone;

endmodule

// File: doc/fft_input_unpacker.md
Name: fft_input_unpacker

Overview:
- Host-side feeder for the FFT core, opposite direction of the FFT result packer.
- Accepts a frame of SAMPLES values as wide INPUT_SIZE-bit lines, 32 samples per line at defaults.
- Buffers the full frame, then streams it to the FFT core one SIZE-bit sample per handshake, with each sample's index.
- Sits between the host read-data path and the FFT core's serial sample input.

Parameters:
- SIZE, 16, bits per sample.
- SAMPLES, 2048, samples per frame.
- INPUT_SIZE, 512, bits per host line.
- Derived, not overridable: LINES_PER_FRAME = SAMPLES*SIZE/INPUT_SIZE (64); SAMPLES_PER_LINE = INPUT_SIZE/SIZE (32).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- line_in  in  INPUT_SIZE  host line; sample k at bits [SIZE*k+SIZE-1 : SIZE*k].
- line_valid  in  1  line_in valid.
- line_ready  out  1  block accepts a line this cycle.
- sample_out  out  SIZE  current sample to FFT core.
- sample_index  out  $clog2(SAMPLES)  frame position of sample_out.
- sample_valid  out  1  sample_out/sample_index valid.
- sample_ready  in  1  FFT core accepts sample.
- frame_done  out  1  one-cycle pulse after the last sample of a frame is accepted.
- busy  out  1  high in DRAIN state.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-low (rst_n), sampled on rising edge.
- Reset values:
  - State FILL; line_ready=1; sample_valid=0; frame_done=0; busy=0.
  - sample_out=0; sample_index=0; line counter=0; read counter=0.
  - Sample storage is not reset (RAM-inferable); contents undefined until written.
- Line handshake:
  - Transfer occurs when line_valid && line_ready at a rising edge.
  - Line number L (0..63) writes samples SAMPLES_PER_LINE*L+k, k=0..31, from the slices above.
- Sample handshake:
  - Transfer occurs when sample_valid && sample_ready.
  - While sample_valid=1 and sample_ready=0, sample_out and sample_index hold stable.
- FILL state:
  - line_ready=1, sample_valid=0.
  - Line counter increments per transfer.
  - On the transfer of line LINES_PER_FRAME-1: counter wraps to 0, next state DRAIN.
- DRAIN state:
  - line_ready=0; line_valid is ignored, and line data presented in DRAIN is not captured.
  - sample_valid is registered: first asserted the cycle after entering DRAIN.
  - sample_out/sample_index then reflect read counter n, initially 0.
  - Each sample transfer advances n; the next sample appears the following cycle, 1-cycle read latency.
  - Throughput: at most one sample per 2 cycles is acceptable; one sample per cycle is preferred and must hold if sample_ready is held high.
  - On transfer of sample n=SAMPLES-1:
    - sample_valid drops next cycle;
    - frame_done pulses high for exactly that one cycle;
    - n wraps to 0; state returns to FILL, so line_ready=1 in that same cycle.
- Arithmetic: counters are unsigned and wrap modulo their range; no saturation; sample data passed unmodified.
- Boundary conditions:
  - line_valid held high continuously: exactly 64 lines taken, then line_ready=0 until frame_done.
  - sample_ready held low indefinitely: block stalls in DRAIN; no data lost or reordered.
  - Reset mid-FILL or mid-DRAIN: on the next edge all outputs and counters take reset values; the partial frame is discarded; no frame_done.
  - Back-to-back frames: a new frame may begin the cycle frame_done is high.

Optional Feature:
- FFT_IN_BITREV_EN defined:
  - Samples are emitted in bit-reversed order for the FFT core's decimation-in-time input.
  - For read count n, sample_out = stored sample bitrev(n) over $clog2(SAMPLES) bits, and sample_index = bitrev(n).
  - Handshake and timing unchanged.
- Undefined: natural order, sample_index = n.

Test Plan:
- Reset, then load 64 lines with sample value = index (line L slice k = 32L+k), sample_ready=1 -> 2048 samples out with sample_out == sample_index == 0..2047 in order; frame_done high exactly once, the cycle after index 2047 is accepted.
- Random line_valid gaps plus random sample_ready backpressure -> identical output sequence; sample_out/sample_index stable during every stall; no line accepted while busy=1.
- line_valid held high across the frame boundary with 65+ lines offered -> line 64 not accepted until frame_done cycle; the second frame's first sample equals slice 0 of line 64.
- Assert rst_n=0 after 30 lines, release, load a full frame of 0xA5A5 -> all 2048 outputs 0xA5A5; no frame_done before the complete new frame drains.
- Reset asserted mid-DRAIN at sample 1000 -> next cycle sample_valid=0, busy=0, line_ready=1, frame_done=0.
- With FFT_IN_BITREV_EN, index-valued frame -> outputs in order 0, 1024, 512, 1536, ...; sample_out == sample_index throughout.
